serial_tx_port: RTL and testbench
=================================

# serial_tx_port

Bus-mapped UART transmitter that answers the shared operand-memory bus (enable/rw/addr/data) alongside the Mem banks and the simulation serial model. Byte writes from the core are queued in a small FIFO and shifted out on `txd` as 8N1 frames at a fixed clocks-per-bit rate. A status word is readable on the same bus. This is the synthesizable replacement for the simulation-only serial sink.

## Interface
- `BASE`, default 8: data register address; status register is at `BASE+1`.
- `CLKDIV`, default 16: clock cycles per serial bit; must be at least 2.
- `DEPTH_LOG2`, default 2: FIFO depth is 2^DEPTH_LOG2 bytes (4 by default).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  bus cycle valid.
- `rw`  in  1  1 = write, 0 = read.
- `addr`  in  32  bus address; the full 32 bits are decoded.
- `data`  inout  32  bus data; this block drives it only for its own reads, otherwise high-Z.
- `txd`  out  1  serial output; idles high.

## Operation
- Address decode is an exact match on `BASE` or `BASE+1`. Any other address has no effect, and `data` stays `'bz`.
- **Write to BASE:** `data[7:0]` is pushed into the FIFO. Upper bits are ignored.
- **Push rules:**
  - A push is accepted if count < DEPTH, or if a pop happens on the same edge.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- **Write to BASE+1:** ignored.
- **Read BASE:** `data` is driven combinationally with the FIFO count, zero-extended to 32 bits.
- **Read BASE+1:** `data` is driven combinationally with the status word:
  - bit0 = full
  - bit1 = empty
  - bit2 = idle (state IDLE and FIFO empty)
  - bit3 = overflow
  - bits 31:4 = 0
- **Overflow clear:** `overflow` clears on every rising edge where `enable & !rw & addr==BASE+1`. A push that overflows on that same edge wins, and `overflow` stays set.
- **Transmit FSM states:** IDLE, START, DATA, STOP. A bit counter counts 0..CLKDIV-1 and a bit index counts 0..7.
  - **IDLE:** `txd` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - **START:** `txd` = 0 for CLKDIV cycles, then go to DATA.
  - **DATA:** `txd` = shift[0], LSB first. Each bit lasts CLKDIV cycles. After bit 7, go to STOP.
  - **STOP:** `txd` = 1 for CLKDIV cycles. If the FIFO is non-empty on the last cycle, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- `txd` is a registered output and is glitch-free.

## Timing
- **Reset values:**
  - `txd` = 1
  - state = IDLE
  - FIFO empty (count 0)
  - `overflow` = 0
  - counters = 0
  - `data` = high-Z
- **Reset mid-frame:** the frame is aborted, `txd` = 1 after the reset edge, and queued bytes are discarded.
- **Write-to-line latency:** a write captured at edge N into an idle, empty block is popped at edge N+1. `txd` falls after edge N+1.
- **Frame length:** 10·CLKDIV cycles.
- **Back-to-back frames:** consecutive frames are contiguous. The next start bit begins on the edge that ends the previous stop bit.
- **Read data:** valid while the read is asserted, with combinational delay only. Status reflects register state before the next edge.
- **Simultaneous push and pop:** count is unchanged. This applies when full as well.
- **Wrap-around:** FIFO pointers are DEPTH_LOG2 bits wide and wrap naturally. Count is DEPTH_LOG2+1 bits wide.

## Configuration
- **`SERIAL_TX_PARITY_EN` defined:**
  - An even-parity bit (XOR of the 8 data bits) is sent for CLKDIV cycles between DATA and STOP, via an extra PARITY state.
  - Frame length is 11·CLKDIV cycles.
- **`SERIAL_TX_PARITY_EN` undefined:** the PARITY state and its logic are absent, and the frame is 8N1 (10·CLKDIV cycles).

## Test plan
All scenarios use BASE=8, CLKDIV=4, DEPTH_LOG2=2.

1. **Reset and idle status:** assert `reset` for 2 cycles, then read addr 9 → `data`=0x6 and `txd`=1 throughout.
2. **Single byte:** write 65 (0x41) to addr 8 at edge N.
   - `txd` goes low after N+1.
   - Then bits 1,0,0,0,0,0,1,0, 4 cycles each, then high.
   - The frame ends 40 cycles after N+1.
   - Read addr 9 afterwards → 0x6.
3. **Overflow:**
   - Write bytes 1..6 to addr 8 on 6 consecutive edges.
   - Read addr 8 → 4; read addr 9 → 0x9 (full, overflow).
   - Read addr 9 again → 0x1.
   - Bytes 1..5 are sent as contiguous frames (200 cycles total); byte 6 is never sent.
4. **Reset mid-frame:** write 0x00, assert `reset` 12 cycles into the frame → `txd`=1 the next cycle, status 0x6, no further low bits.
5. **Unmapped address:** read and write at addr 10 and addr 7 → `data` is never driven by this block, FIFO count stays 0, `txd` stays 1.
6. **Parity (macro defined):**
   - Send 0x41 → parity bit 0.
   - Send 0x07 → parity bit 1.
   - Each frame is 44 cycles.

Source files
------------

// File: rtl/serial_tx_port_if.sv
// Operand-memory bus control lines: the core drives them (master), mapped devices sample them (slave).
// The bidirectional data lines stay a plain inout on each device so the tri-state resolves on the owner's net.
interface serial_tx_port_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;

    modport master (output enable, output rw, output addr);
    modport slave  (input enable, input rw, input addr);
endinterface

// File: rtl/serial_tx_port.sv
// Bus-mapped UART transmitter: byte FIFO at BASE, status at BASE+1, 8N1 frames on txd.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx_port #(
    parameter int BASE       = 8,
    parameter int CLKDIV     = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic            clk,
    input  logic            reset,
    serial_tx_port_if.slave bus,
    inout  wire  [31:0]     data,
    output logic            txd
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [31:0]         A_DATA   = 32'(BASE);
    localparam logic [31:0]         A_STAT   = 32'(BASE + 1);
    localparam logic [CW-1:0]       BIT_LAST = CW'(CLKDIV - 1);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [CW-1:0]         r_bitcnt;
    logic [2:0]            r_bitidx;
    logic [7:0]            r_shift;
    logic                  r_txd;
`ifdef SERIAL_TX_PARITY_EN
    logic                  r_par;
`endif

    logic        w_sel_data;
    logic        w_sel_stat;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_bit_end;
    logic        w_txd_d;
    logic        w_rd_en;
    logic [31:0] w_rd_data;
    logic        w_unused_hi;

    assign w_sel_data  = bus.enable && (bus.addr == A_DATA);
    assign w_sel_stat  = bus.enable && (bus.addr == A_STAT);
    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push_req  = w_sel_data && bus.rw;
    // A full FIFO still accepts a byte when the transmitter pops on the same edge.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_bit_end   = (r_bitcnt == BIT_LAST);
    assign w_unused_hi = ^data[31:8];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            // A dropped byte outranks the read-to-clear on the same edge.
            if (w_push_req && !w_push)       r_overflow <= 1'b1;
            else if (w_sel_stat && !bus.rw)  r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_bitidx <= '0;
            r_txd    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_txd   <= w_txd_d;
            if (r_state == S_IDLE || w_bit_end) r_bitcnt <= '0;
            else                                r_bitcnt <= r_bitcnt + 1'b1;
            if (r_state == S_DATA && w_bit_end) r_bitidx <= r_bitidx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop)                               r_shift <= r_mem[r_rptr];
        else if (r_state == S_DATA && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (w_pop) r_par <= ^r_mem[r_rptr];
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next = S_START;
            S_START:  if (w_bit_end) w_next = S_DATA;
`ifdef SERIAL_TX_PARITY_EN
            S_DATA:   if (w_bit_end && r_bitidx == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
`else
            S_DATA:   if (w_bit_end && r_bitidx == 3'd7) w_next = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_next = w_empty ? S_IDLE : S_START;
            default:  w_next = S_IDLE;
        endcase
    end

    // txd is registered from the next state, so the line follows the state on the same edge.
    always_comb begin
        w_pop   = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_bit_end));
        w_txd_d = 1'b1;
        case (w_next)
            S_START:  w_txd_d = 1'b0;
            S_DATA:   w_txd_d = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_txd_d = r_par;
`endif
            default:  w_txd_d = 1'b1;
        endcase
    end

    assign w_rd_en = !bus.rw && (w_sel_data || w_sel_stat);

    always_comb begin
        w_rd_data = '0;
        if (w_sel_data) begin
            w_rd_data[DEPTH_LOG2:0] = r_count;
        end else begin
            w_rd_data[0] = w_full;
            w_rd_data[1] = w_empty;
            w_rd_data[2] = (r_state == S_IDLE) && w_empty;
            w_rd_data[3] = r_overflow;
        end
    end

    assign data = w_rd_en ? w_rd_data : 32'bz;
    assign txd  = r_txd;

endmodule

// File: tb/tb_serial_tx_port.sv
// Directed bench for serial_tx_port with BASE=8, CLKDIV=4, DEPTH_LOG2=2.
module tb_serial_tx_port;
    localparam int CLKDIV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CLKDIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] r_drv;
    logic        r_drv_en;
    wire  [31:0] data;
    logic        txd;
    int          n_checks = 0;
    int          n_errors = 0;

    serial_tx_port_if bus ();

    serial_tx_port #(.BASE(8), .CLKDIV(CLKDIV), .DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data),
        .txd   (txd)
    );

    assign data = r_drv_en ? r_drv : 32'bz;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sample_data();
        logic [31:0] s;
        for (int i = 0; i < 32; i++) s[i] = (data[i] === 1'b1);
        return s;
    endfunction

    function automatic logic [63:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        logic [63:0] v;
`ifdef SERIAL_TX_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b1, 1'b1, b, 1'b0};
`endif
        v = '0;
        for (int k = 0; k < FL; k++) v[k] = f[k / CLKDIV];
        return v;
    endfunction

    task automatic bus_idle();
        bus.enable = 1'b0;
        bus.rw     = 1'b0;
        bus.addr   = '0;
        r_drv      = '0;
        r_drv_en   = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.enable = 1'b1;
        bus.rw     = 1'b1;
        bus.addr   = a;
        r_drv      = v;
        r_drv_en   = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.enable = 1'b1;
        bus.rw     = 1'b0;
        bus.addr   = a;
        #1;
        v = sample_data();
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    // Waits (bounded) for a start bit, then records one frame, one sample per cycle.
    task automatic capture_frame(input int max_wait, output int waited, output logic [63:0] v);
        waited = 0;
        v      = '0;
        @(negedge clk);
        while (txd !== 1'b0 && waited < max_wait) begin
            waited++;
            @(negedge clk);
        end
        if (txd === 1'b0) begin
            for (int k = 0; k < FL; k++) begin
                v[k] = txd;
                if (k < FL - 1) @(negedge clk);
            end
        end else begin
            waited = -1;
        end
    endtask

    task automatic quiet(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic [63:0] fv;
        int          w;
        int          lows;

        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_txd", txd, 1);
        bus_read(32'd9, rv);
        check("rst_status", rv, 32'h6);
        bus_read(32'd8, rv);
        check("rst_count", rv, 32'h0);
        quiet(8, lows);
        check("rst_txd_quiet", lows, 0);

        // Single byte; upper data bits must be ignored.
        bus_write(32'd8, 32'hFFFF_FF41);
        capture_frame(20, w, fv);
        check("single_latency", w, 1);
        check("single_frame", fv, frame_bits(8'h41));
        bus.enable = 1'b1;
        bus.rw     = 1'b0;
        bus.addr   = 32'd9;
        #1;
        check("single_last_stop_status", sample_data(), 32'h2);
        @(posedge clk);
        #1;
        check("single_end_status", sample_data(), 32'h6);
        bus_idle();

        // Overflow and contiguous frames.
        fork
            begin
                for (int i = 1; i <= 6; i++) bus_write(32'd8, 32'(i));
                bus_read(32'd8, rv);
                check("ovf_count", rv, 32'h4);
                bus_read(32'd9, rv);
                check("ovf_status", rv, 32'h9);
                bus_read(32'd9, rv);
                check("ovf_cleared", rv, 32'h1);
            end
            begin
                int          fw;
                logic [63:0] fr;
                int          fl;
                for (int f = 0; f < 5; f++) begin
                    capture_frame((f == 0) ? 40 : 0, fw, fr);
                    if (f > 0) check("ovf_gap", fw, 0);
                    check("ovf_frame", fr, frame_bits(8'(f + 1)));
                end
                quiet(3 * FL, fl);
                check("ovf_byte6_dropped", fl, 0);
            end
        join
        bus_read(32'd9, rv);
        check("ovf_end_status", rv, 32'h6);

        // Reset in the middle of a frame with a second byte queued.
        bus_write(32'd8, 32'h0);
        bus_write(32'd8, 32'h0);
        repeat (12) @(negedge clk);
        check("midrst_low_before", txd, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_txd", txd, 1);
        reset = 1'b0;
        bus_read(32'd9, rv);
        check("midrst_status", rv, 32'h6);
        bus_read(32'd8, rv);
        check("midrst_count", rv, 32'h0);
        quiet(2 * FL, lows);
        check("midrst_quiet", lows, 0);

        // Unmapped addresses.
        bus_read(32'd10, rv);
        check("unmapped_rd10", rv, 32'h0);
        bus_read(32'd7, rv);
        check("unmapped_rd7", rv, 32'h0);
        bus_write(32'd10, 32'h55);
        bus_write(32'd7, 32'h55);
        bus_write(32'd9, 32'h55);
        bus_read(32'd8, rv);
        check("unmapped_count", rv, 32'h0);
        bus_read(32'd9, rv);
        check("unmapped_status", rv, 32'h6);
        quiet(2 * FL, lows);
        check("unmapped_quiet", lows, 0);

`ifdef SERIAL_TX_PARITY_EN
        bus_write(32'd8, 32'h41);
        capture_frame(20, w, fv);
        check("par41_frame", fv, frame_bits(8'h41));
        check("par41_bit", fv[9 * CLKDIV], 0);
        bus_write(32'd8, 32'h07);
        capture_frame(20, w, fv);
        check("par07_frame", fv, frame_bits(8'h07));
        check("par07_bit", fv[9 * CLKDIV], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
